// File: rtl/alu_pkg.sv
// alu_pkg: opcode, flag and state types shared by the alu_seq design (Rev 1.0).
// NUM_OPS grows to cover DIVU/REMU/DIV when ALU_DIV_EN is defined.
`default_nettype none

package alu_pkg;

  localparam int ALU_OPW = 4;

  typedef enum logic [ALU_OPW-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10,
    OP_DIVU = 4'd11,
    OP_REMU = 4'd12,
    OP_DIV  = 4'd13
  } alu_op_e;

  typedef struct packed {
    logic err;
    logic ovf;
    logic carry;
    logic neg;
    logic zero;
  } alu_flags_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

`ifdef ALU_DIV_EN
  localparam int NUM_OPS = 14;
`else
  localparam int NUM_OPS = 11;
`endif

endpackage

`default_nettype wire

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, one partial product per clock over WIDTH cycles.
// Rev 1.0
`default_nettype none

module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_prod
);

  localparam int            c_cw   = $clog2(WIDTH);
  localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);

  logic                 r_busy;
  logic [c_cw-1:0]      r_cnt;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   w_acc_nxt;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

  // The final partial sum is presented combinationally so the caller can
  // capture the full product on the same edge the counter expires.
  assign o_done = r_busy && (r_cnt == c_last);
  assign o_prod = w_acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + c_cw'(1);
      if (r_cnt == c_last) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready on request and result sides; iterative MUL.
// Optional restoring divider (DIVU/REMU/DIV) enabled by defining ALU_DIV_EN. Rev 1.0
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [4:0]       out_flags
);

  localparam int c_sw = $clog2(WIDTH);

  alu_state_e         r_state;
  alu_state_e         w_state_nxt;
  logic               w_accept;
  logic               w_start;
  logic               w_legal;
  logic               w_iter;
  logic               w_mul_done;
  alu_op_e            w_op;
  logic [OPW-1:0]     r_op;
  logic [WIDTH-1:0]   r_res;
  alu_flags_t         r_flags;
  logic [WIDTH-1:0]   w_sc_res;
  alu_flags_t         w_sc_flags;
  logic [WIDTH-1:0]   w_it_res;
  alu_flags_t         w_it_flags;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_dif;
  logic [c_sw-1:0]    w_shamt;

  assign w_legal = (in_op < OPW'(NUM_OPS));
  assign w_op    = alu_op_e'(in_op);
  assign w_shamt = in_b[c_sw-1:0];
  assign w_sum   = {1'b0, in_a} + {1'b0, in_b};
  // a + ~b + 1 leaves bit WIDTH set exactly when no borrow occurred.
  assign w_dif   = {1'b0, in_a} + {1'b0, ~in_b} + (WIDTH+1)'(1);

`ifdef ALU_DIV_EN
  assign w_iter = w_legal && ((w_op == OP_MUL) ||
                  (((w_op == OP_DIVU) || (w_op == OP_REMU) || (w_op == OP_DIV)) && (in_b != '0)));
`else
  assign w_iter = w_legal && (w_op == OP_MUL);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_accept    = 1'b0;
    w_start     = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_start     = w_iter;
          w_state_nxt = w_iter ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (w_mul_done) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_sc_res   = '0;
    w_sc_flags = '0;
    if (!w_legal) begin
      w_sc_flags.err = 1'b1;
    end else begin
      unique case (w_op)
        OP_ADD: begin
          w_sc_res         = w_sum[WIDTH-1:0];
          w_sc_flags.carry = w_sum[WIDTH];
          w_sc_flags.ovf   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (w_sum[WIDTH-1] != in_a[WIDTH-1]);
        end
        OP_SUB: begin
          w_sc_res         = w_dif[WIDTH-1:0];
          w_sc_flags.carry = w_dif[WIDTH];
          w_sc_flags.ovf   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (w_dif[WIDTH-1] != in_a[WIDTH-1]);
        end
        OP_AND:  w_sc_res = in_a & in_b;
        OP_OR:   w_sc_res = in_a | in_b;
        OP_XOR:  w_sc_res = in_a ^ in_b;
        OP_SLL:  w_sc_res = in_a << w_shamt;
        OP_SRL:  w_sc_res = in_a >> w_shamt;
        OP_SRA:  w_sc_res = $unsigned($signed(in_a) >>> w_shamt);
        OP_SLT:  w_sc_res[0] = ($signed(in_a) < $signed(in_b));
        OP_SLTU: w_sc_res[0] = (in_a < in_b);
`ifdef ALU_DIV_EN
        // Only reached with a zero divisor; nonzero divisors iterate.
        OP_DIVU, OP_DIV: begin
          w_sc_res       = '1;
          w_sc_flags.err = 1'b1;
        end
        OP_REMU: begin
          w_sc_res       = in_a;
          w_sc_flags.err = 1'b1;
        end
`endif
        default: w_sc_res = '0;
      endcase
    end
    w_sc_flags.zero = (w_sc_res == '0);
    w_sc_flags.neg  = w_sc_res[WIDTH-1];
  end

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_a     (in_a),
    .i_b     (in_b),
    .o_done  (w_mul_done),
    .o_prod  (w_prod)
  );

`ifdef ALU_DIV_EN
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic             r_div_neg;
  logic             r_div_ovf;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH+1:0] w_trial;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_rem_nxt;

  assign w_a_neg  = (in_op == OPW'(OP_DIV)) && in_a[WIDTH-1];
  assign w_b_neg  = (in_op == OPW'(OP_DIV)) && in_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (~in_a + WIDTH'(1)) : in_a;
  assign w_b_mag  = w_b_neg ? (~in_b + WIDTH'(1)) : in_b;

  // Restoring step: dividend bits shift out of r_quo into the remainder
  // while quotient bits shift in from the right.
  assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
  assign w_trial   = {1'b0, w_rem_sh} - {2'b00, r_dvs};
  assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_trial[WIDTH+1]};
  assign w_rem_nxt = w_trial[WIDTH+1] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo     <= '0;
      r_rem     <= '0;
      r_dvs     <= '0;
      r_div_neg <= 1'b0;
      r_div_ovf <= 1'b0;
    end else if (w_start) begin
      r_quo     <= w_a_mag;
      r_rem     <= '0;
      r_dvs     <= w_b_mag;
      r_div_neg <= w_a_neg ^ w_b_neg;
      r_div_ovf <= (in_op == OPW'(OP_DIV)) && (in_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&in_b);
    end else if (r_state == BUSY) begin
      r_quo <= w_quo_nxt;
      r_rem <= w_rem_nxt;
    end
  end
`endif

  always_comb begin
    w_it_res   = '0;
    w_it_flags = '0;
    if (r_op == OPW'(OP_MUL)) begin
      w_it_res         = w_prod[WIDTH-1:0];
      w_it_flags.carry = |w_prod[2*WIDTH-1:WIDTH];
    end
`ifdef ALU_DIV_EN
    else if (r_op == OPW'(OP_REMU)) begin
      w_it_res = w_rem_nxt;
    end else if (r_op == OPW'(OP_DIVU)) begin
      w_it_res = w_quo_nxt;
    end else begin
      w_it_res       = r_div_neg ? (~w_quo_nxt + WIDTH'(1)) : w_quo_nxt;
      w_it_flags.ovf = r_div_ovf;
    end
`else
    else begin
      w_it_flags.err = 1'b1;
    end
`endif
    w_it_flags.zero = (w_it_res == '0);
    w_it_flags.neg  = w_it_res[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_res   <= '0;
      r_flags <= '0;
    end else if (w_accept) begin
      r_op <= in_op;
      if (!w_iter) begin
        r_res   <= w_sc_res;
        r_flags <= w_sc_flags;
      end
    end else if ((r_state == BUSY) && w_mul_done) begin
      r_res   <= w_it_res;
      r_flags <= w_it_flags;
    end
  end

  assign out_res   = r_res;
  assign out_flags = r_flags;

endmodule

`default_nettype wire
